// File: rtl/operand_fetch.sv
// Operand fetch stage: reads/bypasses source operands, tracks pending destination
// registers in a scoreboard, and holds one issued instruction under a valid/ready handshake.
module operand_fetch #(
  parameter bit TRACK_ALL = 1'b0
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [4:0]  rs1_sel_o,
  output logic [4:0]  rs2_sel_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] wb_data_i,
  input  logic [4:0]  wb_sel_i,
  input  logic        wb_en_i,
  input  logic        flush_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [31:0] r_pending;

  logic        w_wbClr;
  logic        w_heldSets;
  logic [4:0]  w_heldRd;
  logic        w_haz1;
  logic        w_haz2;
  logic        w_hazard;
  logic        w_accept;
  logic        w_issueSet;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [31:0] w_pendingNext;

  function automatic logic wouldSet(input logic [31:0] instr);
    logic [6:0] opc;
    opc = instr[6:0];
    return (instr[11:7] != 5'd0) &&
           ((opc == OPC_LOAD) ||
            (TRACK_ALL && (opc != OPC_STORE) && (opc != OPC_BRANCH)));
  endfunction

  function automatic logic [31:0] selectOperand(input logic [4:0] sel,
                                                input logic [31:0] rfData,
                                                input logic wbEn,
                                                input logic [4:0] wbSel,
                                                input logic [31:0] wbData);
    if (sel == 5'd0)
      return 32'd0;
    else if (wbEn && (wbSel != 5'd0) && (wbSel == sel))
      return wbData;
    else
      return rfData;
  endfunction

  assign rs1_sel_o = instr_i[19:15];
  assign rs2_sel_o = instr_i[24:20];

  assign w_op1 = selectOperand(rs1_sel_o, rs1_data_i, wb_en_i, wb_sel_i, wb_data_i);
  assign w_op2 = selectOperand(rs2_sel_o, rs2_data_i, wb_en_i, wb_sel_i, wb_data_i);

  // A source stalls if its register is pending and not written back this cycle,
  // or if the held instruction will mark it pending when it issues.
  assign w_wbClr    = wb_en_i && (wb_sel_i != 5'd0);
  assign w_heldSets = r_valid && wouldSet(r_instr);
  assign w_heldRd   = r_instr[11:7];
  assign w_haz1 = (rs1_sel_o != 5'd0) &&
                  ((r_pending[rs1_sel_o] && !(w_wbClr && (wb_sel_i == rs1_sel_o))) ||
                   (w_heldSets && (w_heldRd == rs1_sel_o)));
  assign w_haz2 = (rs2_sel_o != 5'd0) &&
                  ((r_pending[rs2_sel_o] && !(w_wbClr && (wb_sel_i == rs2_sel_o))) ||
                   (w_heldSets && (w_heldRd == rs2_sel_o)));
  assign w_hazard = w_haz1 || w_haz2;

  assign ready_o  = !flush_i && !w_hazard && (!r_valid || ready_i);
  assign w_accept = valid_i && ready_o;
  // A flushed entry is discarded, so it never marks its destination pending.
  assign w_issueSet = r_valid && ready_i && !flush_i && wouldSet(r_instr);

  // Set wins over clear when both target the same register.
  always_comb begin
    w_pendingNext = r_pending;
    if (w_wbClr)
      w_pendingNext[wb_sel_i] = 1'b0;
    if (w_issueSet)
      w_pendingNext[w_heldRd] = 1'b1;
    w_pendingNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_valid   <= 1'b0;
      r_pc      <= 32'd0;
      r_instr   <= 32'd0;
      r_op1     <= 32'd0;
      r_op2     <= 32'd0;
      r_pending <= 32'd0;
    end else begin
      r_pending <= w_pendingNext;
      if (flush_i) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_pc    <= pc_i;
        r_instr <= instr_i;
        r_op1   <= w_op1;
        r_op2   <= w_op2;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign valid_o = r_valid;
  assign pc_o    = r_pc;
  assign instr_o = r_instr;
  assign op1_o   = r_op1;
  assign op2_o   = r_op2;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed testbench for operand_fetch: issue, bypass, load-use and back-to-back
// hazards, backpressure, flush and asynchronous reset.
module tb_operand_fetch;

  logic        clk;
  logic        reset_i;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  rs1_sel_o;
  logic [4:0]  rs2_sel_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] wb_data_i;
  logic [4:0]  wb_sel_i;
  logic        wb_en_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [31:0] op1_o;
  logic [31:0] op2_o;

  logic [31:0] regFile [32];
  int          compareCount;
  int          failCount;

  operand_fetch #(.TRACK_ALL(1'b0)) dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .rs1_sel_o  (rs1_sel_o),
    .rs2_sel_o  (rs2_sel_o),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .wb_data_i  (wb_data_i),
    .wb_sel_i   (wb_sel_i),
    .wb_en_i    (wb_en_i),
    .flush_i    (flush_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .pc_o       (pc_o),
    .instr_o    (instr_o),
    .op1_o      (op1_o),
    .op2_o      (op2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model answers reads combinationally from the selects.
  assign rs1_data_i = regFile[rs1_sel_o];
  assign rs2_data_i = regFile[rs2_sel_o];

  function automatic logic [31:0] encAdd(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] encLw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive inputs on the falling edge so they are settled well before the rising edge.
  task automatic applyStimulus(input logic vld, input logic [31:0] instr,
                               input logic [31:0] pc, input logic rdy,
                               input logic wbEn, input logic [4:0] wbSel,
                               input logic [31:0] wbData, input logic flush);
    @(negedge clk);
    valid_i   = vld;
    instr_i   = instr;
    pc_i      = pc;
    ready_i   = rdy;
    wb_en_i   = wbEn;
    wb_sel_i  = wbSel;
    wb_data_i = wbData;
    flush_i   = flush;
    #1;
  endtask

  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] lwX5;
    logic [31:0] addX3;
    logic [31:0] addX6;
    compareCount = 0;
    failCount    = 0;
    for (int i = 0; i < 32; i++) regFile[i] = 32'd0;
    regFile[1] = 32'd5;
    regFile[2] = 32'd7;
    regFile[5] = 32'h55;
    lwX5  = encLw(5'd5, 5'd1);
    addX3 = encAdd(5'd3, 5'd1, 5'd2);
    addX6 = encAdd(5'd6, 5'd5, 5'd0);

    reset_i = 1'b0;
    valid_i = 1'b0; instr_i = 32'd0; pc_i = 32'd0; ready_i = 1'b0;
    wb_en_i = 1'b0; wb_sel_i = 5'd0; wb_data_i = 32'd0; flush_i = 1'b0;
    #12;
    checkOutput("reset valid_o", {31'd0, valid_o}, 32'd0);
    checkOutput("reset pc_o", pc_o, 32'd0);
    checkOutput("reset op1_o", op1_o, 32'd0);
    checkOutput("reset ready_o", {31'd0, ready_o}, 32'd1);
    @(negedge clk);
    reset_i = 1'b1;

    // Plain issue of add x3,x1,x2
    applyStimulus(1'b1, addX3, 32'h100, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("rs1_sel", {27'd0, rs1_sel_o}, 32'd1);
    checkOutput("rs2_sel", {27'd0, rs2_sel_o}, 32'd2);
    checkOutput("plain ready_o", {31'd0, ready_o}, 32'd1);
    clockEdge();
    checkOutput("plain valid_o", {31'd0, valid_o}, 32'd1);
    checkOutput("plain op1", op1_o, 32'd5);
    checkOutput("plain op2", op2_o, 32'd7);
    checkOutput("plain pc", pc_o, 32'h100);
    checkOutput("plain instr", instr_o, addX3);

    // Writeback bypass onto rs1
    applyStimulus(1'b1, addX3, 32'h104, 1'b1, 1'b1, 5'd1, 32'h99, 1'b0);
    clockEdge();
    checkOutput("bypass op1", op1_o, 32'h99);
    checkOutput("bypass op2", op2_o, 32'd7);
    checkOutput("bypass pc", pc_o, 32'h104);

    // lw x5 accepted, then dependent add stalls on the held load
    applyStimulus(1'b1, lwX5, 32'h108, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    clockEdge();
    checkOutput("lw valid_o", {31'd0, valid_o}, 32'd1);
    checkOutput("lw instr", instr_o, lwX5);
    applyStimulus(1'b1, encAdd(5'd7, 5'd5, 5'd5), 32'h10c, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("b2b ready_o", {31'd0, ready_o}, 32'd0);
    clockEdge();
    checkOutput("b2b valid_o", {31'd0, valid_o}, 32'd0);

    // Load-use: stall on pending x5 until its writeback arrives
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, addX6, 32'h110, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      checkOutput("loaduse stall ready_o", {31'd0, ready_o}, 32'd0);
      clockEdge();
      checkOutput("loaduse stall valid_o", {31'd0, valid_o}, 32'd0);
    end
    applyStimulus(1'b1, addX6, 32'h110, 1'b1, 1'b1, 5'd5, 32'h1234, 1'b0);
    checkOutput("loaduse wb ready_o", {31'd0, ready_o}, 32'd1);
    clockEdge();
    checkOutput("loaduse valid_o", {31'd0, valid_o}, 32'd1);
    checkOutput("loaduse op1", op1_o, 32'h1234);
    checkOutput("loaduse op2", op2_o, 32'd0);

    // Backpressure on a held lw x5, then flush it
    applyStimulus(1'b1, lwX5, 32'h200, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("pre-hold ready_o", {31'd0, ready_o}, 32'd1);
    clockEdge();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, encAdd(5'd9, 5'd1, 5'd2), 32'h204, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      checkOutput("hold ready_o", {31'd0, ready_o}, 32'd0);
      clockEdge();
      checkOutput("hold valid_o", {31'd0, valid_o}, 32'd1);
      checkOutput("hold pc", pc_o, 32'h200);
      checkOutput("hold instr", instr_o, lwX5);
      checkOutput("hold op1", op1_o, 32'd5);
    end
    applyStimulus(1'b1, encAdd(5'd9, 5'd1, 5'd2), 32'h204, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    checkOutput("flush ready_o", {31'd0, ready_o}, 32'd0);
    clockEdge();
    checkOutput("flush valid_o", {31'd0, valid_o}, 32'd0);
    applyStimulus(1'b1, addX6, 32'h208, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("post-flush ready_o", {31'd0, ready_o}, 32'd1);
    clockEdge();
    checkOutput("post-flush op1", op1_o, 32'h55);

    // Reset with x5 pending and a valid entry held
    applyStimulus(1'b1, lwX5, 32'h300, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    clockEdge();
    applyStimulus(1'b1, encAdd(5'd8, 5'd1, 5'd2), 32'h304, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    clockEdge();
    checkOutput("pre-reset valid_o", {31'd0, valid_o}, 32'd1);
    applyStimulus(1'b1, addX6, 32'h308, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("pre-reset pending ready_o", {31'd0, ready_o}, 32'd0);
    reset_i = 1'b0;
    #1;
    checkOutput("async reset valid_o", {31'd0, valid_o}, 32'd0);
    checkOutput("async reset pc", pc_o, 32'd0);
    checkOutput("async reset instr", instr_o, 32'd0);
    applyStimulus(1'b0, addX6, 32'h308, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    reset_i = 1'b1;
    checkOutput("release valid_o", {31'd0, valid_o}, 32'd0);
    applyStimulus(1'b1, addX6, 32'h308, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("post-reset ready_o", {31'd0, ready_o}, 32'd1);
    clockEdge();
    checkOutput("post-reset valid_o", {31'd0, valid_o}, 32'd1);
    checkOutput("post-reset op1", op1_o, 32'h55);
    checkOutput("post-reset pc", pc_o, 32'h308);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
